// File: rtl/mem_stage_pkg.sv
// Shared RV32I memory-stage types: funct3 encodings, access sizes and the MEM FSM states.
// Consumed by mem_align and mem_stage (MEM_MISALIGN_TRAP_EN is handled in mem_stage).
package mem_stage_pkg;

    typedef enum logic [2:0] {
        LF_B  = 3'b000,
        LF_H  = 3'b001,
        LF_W  = 3'b010,
        LF_BU = 3'b100,
        LF_HU = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        SF_B = 3'b000,
        SF_H = 3'b001,
        SF_W = 3'b010
    } store_funct3_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } access_size_t;

    // Any funct3 outside the defined set is treated as a full word.
    function automatic access_size_t decode_size(input logic [2:0] funct3,
                                                 input logic       is_store);
        access_size_t size;
        size = SZ_W;
        if (is_store) begin
            case (funct3)
                SF_B:    size = SZ_B;
                SF_H:    size = SZ_H;
                default: size = SZ_W;
            endcase
        end else begin
            case (funct3)
                LF_B, LF_BU: size = SZ_B;
                LF_H, LF_HU: size = SZ_H;
                default:     size = SZ_W;
            endcase
        end
        return size;
    endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational lane logic: byte enables and shifted store data, plus load lane
// extraction and sign/zero extension. Halfwords use only addr[1], words ignore addr[1:0].
module mem_align
    import mem_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic            is_store,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] wdata_raw,
    input  logic [XLEN-1:0] rdata_raw,
    output logic [3:0]      mbe,
    output logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] rdata_ext,
    output logic            misaligned
);

    access_size_t    size;
    logic [1:0]      lane;
    logic [XLEN-1:0] rshift;

    always_comb begin
        size       = decode_size(funct3, is_store);
        lane       = 2'b00;
        mbe        = 4'b1111;
        misaligned = 1'b0;
        case (size)
            SZ_B: begin
                lane = addr_lo;
                mbe  = 4'b0001 << addr_lo;
            end
            SZ_H: begin
                lane       = {addr_lo[1], 1'b0};
                mbe        = 4'b0011 << lane;
                misaligned = addr_lo[0];
            end
            default: begin
                lane       = 2'b00;
                mbe        = 4'b1111;
                misaligned = |addr_lo;
            end
        endcase

        wdata  = wdata_raw << {lane, 3'b000};
        rshift = rdata_raw >> {lane, 3'b000};

        rdata_ext = rshift;
        case (funct3)
            LF_B:    rdata_ext = {{(XLEN-8){rshift[7]}}, rshift[7:0]};
            LF_H:    rdata_ext = {{(XLEN-16){rshift[15]}}, rshift[15:0]};
            LF_BU:   rdata_ext = {{(XLEN-8){1'b0}}, rshift[7:0]};
            LF_HU:   rdata_ext = {{(XLEN-16){1'b0}}, rshift[15:0]};
            default: rdata_ext = rshift;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// RV32I MEM stage: single-outstanding data-memory access FSM (IDLE->BUSY->DONE) and MEM/WB latch.
// Define MEM_MISALIGN_TRAP_EN to squash misaligned h/w accesses and flag mem_misaligned.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            exmem_valid,
    input  logic            exmem_mem_read,
    input  logic            exmem_mem_write,
    input  logic [2:0]      exmem_funct3,
    input  logic [XLEN-1:0] exmem_alu_out,
    input  logic [XLEN-1:0] exmem_rs2_out,
    output logic            dmem_read,
    output logic            dmem_write,
    output logic [3:0]      dmem_mbe,
    output logic [XLEN-1:0] dmem_address,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_resp,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            mem_stall,
    output logic            mem_misaligned,
    output logic            memwb_valid,
    output logic [XLEN-1:0] memwb_alu_out,
    output logic [XLEN-1:0] memwb_rdata,
    output mem_state_t      dbg_state
);

`ifdef MEM_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    // dmem handshake: a request (dmem_read/dmem_write plus mbe/address/wdata) is raised
    // from a register and held unchanged until the one-cycle dmem_resp pulse; the request
    // drops the cycle after that pulse. Only one access is ever outstanding.
    mem_state_t      state_q, state_d;
    logic            mem_op;
    logic            misaligned_raw;
    logic            trap;
    logic [3:0]      mbe_c;
    logic [XLEN-1:0] wdata_c;
    logic [XLEN-1:0] rdata_ext;
    logic [XLEN-1:0] load_data_q;

    mem_align #(.XLEN(XLEN)) u_align (
        .funct3     (exmem_funct3),
        .is_store   (exmem_mem_write),
        .addr_lo    (exmem_alu_out[1:0]),
        .wdata_raw  (exmem_rs2_out),
        .rdata_raw  (dmem_rdata),
        .mbe        (mbe_c),
        .wdata      (wdata_c),
        .rdata_ext  (rdata_ext),
        .misaligned (misaligned_raw)
    );

    assign mem_op    = exmem_valid && (exmem_mem_read || exmem_mem_write);
    assign trap      = TRAP_EN && mem_op && misaligned_raw;
    assign dbg_state = state_q;

    always_comb begin
        state_d        = state_q;
        mem_stall      = 1'b0;
        mem_misaligned = 1'b0;
        case (state_q)
            IDLE: begin
                if (trap) begin
                    mem_misaligned = 1'b1;
                end else if (mem_op) begin
                    mem_stall = 1'b1;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                mem_stall = 1'b1;
                if (dmem_resp) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            dmem_read     <= 1'b0;
            dmem_write    <= 1'b0;
            dmem_mbe      <= '0;
            dmem_address  <= '0;
            dmem_wdata    <= '0;
            load_data_q   <= '0;
            memwb_valid   <= 1'b0;
            memwb_alu_out <= '0;
            memwb_rdata   <= '0;
        end else begin
            state_q <= state_d;

            if (state_q == IDLE && mem_op && !trap) begin
                dmem_read    <= exmem_mem_read;
                dmem_write   <= exmem_mem_write;
                dmem_mbe     <= mbe_c;
                dmem_address <= {exmem_alu_out[XLEN-1:2], 2'b00};
                dmem_wdata   <= wdata_c;
            end

            // The instruction is frozen on exmem_* while BUSY, so its funct3/addr drive extension.
            if (state_q == BUSY && dmem_resp) begin
                dmem_read   <= 1'b0;
                dmem_write  <= 1'b0;
                load_data_q <= exmem_mem_read ? rdata_ext : '0;
            end

            if (!mem_stall) begin
                memwb_valid   <= exmem_valid && !trap;
                memwb_alu_out <= exmem_alu_out;
                memwb_rdata   <= (state_q == DONE) ? load_data_q : '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: table of memory/non-memory instructions with a scoreboard queue for
// MEM/WB results, plus hand sequences for reset, stray responses and reset mid-access.
module tb_mem_stage;
    import mem_stage_pkg::*;

`ifdef MEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        exmem_valid, exmem_mem_read, exmem_mem_write;
    logic [2:0]  exmem_funct3;
    logic [31:0] exmem_alu_out, exmem_rs2_out;
    logic        dmem_read, dmem_write;
    logic [3:0]  dmem_mbe;
    logic [31:0] dmem_address, dmem_wdata;
    logic        dmem_resp;
    logic [31:0] dmem_rdata;
    logic        mem_stall, mem_misaligned;
    logic        memwb_valid;
    logic [31:0] memwb_alu_out, memwb_rdata;
    mem_state_t  dbg_state;

    mem_stage dut (
        .clk             (clk),
        .rst             (rst),
        .exmem_valid     (exmem_valid),
        .exmem_mem_read  (exmem_mem_read),
        .exmem_mem_write (exmem_mem_write),
        .exmem_funct3    (exmem_funct3),
        .exmem_alu_out   (exmem_alu_out),
        .exmem_rs2_out   (exmem_rs2_out),
        .dmem_read       (dmem_read),
        .dmem_write      (dmem_write),
        .dmem_mbe        (dmem_mbe),
        .dmem_address    (dmem_address),
        .dmem_wdata      (dmem_wdata),
        .dmem_resp       (dmem_resp),
        .dmem_rdata      (dmem_rdata),
        .mem_stall       (mem_stall),
        .mem_misaligned  (mem_misaligned),
        .memwb_valid     (memwb_valid),
        .memwb_alu_out   (memwb_alu_out),
        .memwb_rdata     (memwb_rdata),
        .dbg_state       (dbg_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] rs2;
        logic [31:0] rdata;
        int          busy;
        logic        trap;
        logic [3:0]  mbe;
        logic [31:0] wdata;
        logic [31:0] rdata_exp;
    } vec_t;

    vec_t        vecs[12];
    logic [63:0] exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        check32(name, {31'd0, act}, {31'd0, exp});
    endtask

    task automatic apply_vec(input int idx, input vec_t v);
        logic  mem_op, exp_stall, exp_retire;
        logic [63:0] ent;
        string p;
        p          = $sformatf("v%0d_", idx);
        mem_op     = v.valid && (v.rd || v.wr);
        exp_stall  = mem_op && !v.trap;
        exp_retire = v.valid && !v.trap;

        @(posedge clk); #1;
        exmem_valid     = v.valid;
        exmem_mem_read  = v.rd;
        exmem_mem_write = v.wr;
        exmem_funct3    = v.f3;
        exmem_alu_out   = v.addr;
        exmem_rs2_out   = v.rs2;
        dmem_resp       = 1'b0;
        if (exp_retire) exp_q.push_back({v.addr, v.rdata_exp});

        @(negedge clk);
        check1({p, "stall_issue"}, mem_stall, exp_stall);
        check1({p, "misaligned"}, mem_misaligned, v.trap);

        if (exp_stall) begin
            for (int b = 1; b <= v.busy; b++) begin
                @(posedge clk); #1;
                dmem_resp  = (b == v.busy);
                dmem_rdata = (b == v.busy) ? v.rdata : $urandom;
                @(negedge clk);
                check1({p, "stall_busy"}, mem_stall, 1'b1);
                check1({p, "dmem_read"}, dmem_read, v.rd);
                check1({p, "dmem_write"}, dmem_write, v.wr);
                check32({p, "dmem_address"}, dmem_address, v.addr & 32'hFFFF_FFFC);
                if (v.wr) begin
                    check32({p, "dmem_mbe"}, {28'd0, dmem_mbe}, {28'd0, v.mbe});
                    check32({p, "dmem_wdata"}, dmem_wdata, v.wdata);
                end
            end
            @(posedge clk); #1;
            dmem_resp  = 1'b0;
            dmem_rdata = $urandom;
            @(negedge clk);
            check1({p, "stall_done"}, mem_stall, 1'b0);
            check32({p, "state_done"}, {30'd0, dbg_state}, {30'd0, DONE});
        end

        @(posedge clk); #1;
        exmem_valid     = 1'b0;
        exmem_mem_read  = 1'b0;
        exmem_mem_write = 1'b0;
        exmem_alu_out   = $urandom;
        @(negedge clk);
        check1({p, "req_idle_rd"}, dmem_read, 1'b0);
        check1({p, "req_idle_wr"}, dmem_write, 1'b0);
        check1({p, "memwb_valid"}, memwb_valid, exp_retire);
        if (memwb_valid) begin
            if (exp_q.size() == 0) begin
                check1({p, "unexpected_retire"}, 1'b1, 1'b0);
            end else begin
                ent = exp_q.pop_front();
                check32({p, "memwb_alu_out"}, memwb_alu_out, ent[63:32]);
                check32({p, "memwb_rdata"}, memwb_rdata, ent[31:0]);
            end
        end
    endtask

    initial begin
        //             valid rd    wr    f3      addr          rs2           rdata         busy trap  mbe      wdata         rdata_exp
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 3'b000, 32'h0000_0010, 32'h0,        32'h0,        0, 1'b0, 4'b0000, 32'h0,        32'h0};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'h0,        32'h80FF_FF00, 3, 1'b0, 4'b1000, 32'h0,        32'hFFFF_FF80};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 32'h0,        2, 1'b0, 4'b1100, 32'hABCD_0000, 32'h0};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 3'b101, 32'h0000_3002, 32'h0,        32'h8001_0000, 1, 1'b0, 4'b1100, 32'h0,        32'h0000_8001};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_4001, 32'h0,        32'hDEAD_BEEF, 1, TRAP, 4'b1111, 32'h0,        32'hDEAD_BEEF};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 3'b000, 32'h0000_5001, 32'hFFFF_FFA5, 32'h0,        1, 1'b0, 4'b0010, 32'hFFFF_A500, 32'h0};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 3'b001, 32'h0000_6000, 32'h0,        32'h1234_8765, 2, 1'b0, 4'b0011, 32'h0,        32'hFFFF_8765};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 3'b010, 32'h0000_6100, 32'h0,        32'h0,        0, 1'b0, 4'b0000, 32'h0,        32'h0};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 3'b100, 32'h0000_7002, 32'h0,        32'h00AB_0000, 1, 1'b0, 4'b0100, 32'h0,        32'h0000_00AB};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 3'b010, 32'h0000_8000, 32'hCAFE_F00D, 32'h0,        4, 1'b0, 4'b1111, 32'hCAFE_F00D, 32'h0};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 3'b011, 32'h0000_9000, 32'h0,        32'h1122_3344, 1, 1'b0, 4'b1111, 32'h0,        32'h1122_3344};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 3'b001, 32'h0000_A003, 32'h0,        32'hF00D_1234, 2, TRAP, 4'b1100, 32'h0,        32'hFFFF_F00D};

        rst             = 1'b1;
        exmem_valid     = 1'b0;
        exmem_mem_read  = 1'b0;
        exmem_mem_write = 1'b0;
        exmem_funct3    = 3'b000;
        exmem_alu_out   = '0;
        exmem_rs2_out   = '0;
        dmem_resp       = 1'b0;
        dmem_rdata      = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check1("rst_dmem_read", dmem_read, 1'b0);
        check1("rst_dmem_write", dmem_write, 1'b0);
        check32("rst_dmem_mbe", {28'd0, dmem_mbe}, 32'd0);
        check32("rst_dmem_address", dmem_address, 32'd0);
        check32("rst_dmem_wdata", dmem_wdata, 32'd0);
        check1("rst_memwb_valid", memwb_valid, 1'b0);
        check32("rst_memwb_alu_out", memwb_alu_out, 32'd0);
        check32("rst_memwb_rdata", memwb_rdata, 32'd0);
        check1("rst_misaligned", mem_misaligned, 1'b0);
        check32("rst_state", {30'd0, dbg_state}, {30'd0, IDLE});

        // Stray response in IDLE is ignored
        @(posedge clk); #1;
        rst        = 1'b0;
        dmem_resp  = 1'b1;
        dmem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        check1("stray_resp_stall", mem_stall, 1'b0);
        @(posedge clk); #1;
        dmem_resp = 1'b0;
        @(negedge clk);
        check32("stray_resp_state", {30'd0, dbg_state}, {30'd0, IDLE});
        check1("stray_resp_read", dmem_read, 1'b0);
        check1("stray_resp_memwb_valid", memwb_valid, 1'b0);

        for (int i = 0; i < 12; i++) apply_vec(i, vecs[i]);

        // Reset in the middle of an access, after a retiring add
        @(posedge clk); #1;
        exmem_valid     = 1'b1;
        exmem_mem_read  = 1'b0;
        exmem_mem_write = 1'b0;
        exmem_funct3    = 3'b000;
        exmem_alu_out   = 32'h0000_0055;
        @(posedge clk); #1;
        exmem_mem_read = 1'b1;
        exmem_funct3   = 3'b010;
        exmem_alu_out  = 32'h0000_0100;
        @(negedge clk);
        check1("rstmid_stall", mem_stall, 1'b1);
        check1("rstmid_prev_valid", memwb_valid, 1'b1);
        check32("rstmid_prev_alu", memwb_alu_out, 32'h0000_0055);
        @(posedge clk); #1;
        @(negedge clk);
        check32("rstmid_busy_state", {30'd0, dbg_state}, {30'd0, BUSY});
        check1("rstmid_busy_read", dmem_read, 1'b1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst            = 1'b0;
        exmem_valid    = 1'b0;
        exmem_mem_read = 1'b0;
        dmem_resp      = 1'b1;
        dmem_rdata     = 32'h1234_5678;
        @(negedge clk);
        check1("rstmid_read_dropped", dmem_read, 1'b0);
        check32("rstmid_state", {30'd0, dbg_state}, {30'd0, IDLE});
        check1("rstmid_memwb_valid", memwb_valid, 1'b0);
        @(posedge clk); #1;
        dmem_resp = 1'b0;
        @(negedge clk);
        check32("late_resp_state", {30'd0, dbg_state}, {30'd0, IDLE});
        check1("late_resp_read", dmem_read, 1'b0);
        check1("late_resp_stall", mem_stall, 1'b0);
        check1("late_resp_memwb_valid", memwb_valid, 1'b0);

        check32("scoreboard_drained", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
